// File: rtl/cache_miss_ctrl_if.sv
// Cache miss controller bus bundle: lookup-side miss handshake, replacement
// hook, memory line-fetch channel and data/tag array fill port.
// Optional feature macro: CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN adds crit_valid/crit_data.
interface cache_miss_ctrl_if #(
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned NUM_SETS    = 16,
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned BLOCK_WORDS = 4
);
  localparam int unsigned SET_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned TAG_W = ADDR_SIZE - SET_W - OFF_W - 2;

  logic                 miss_valid;
  logic [ADDR_SIZE-1:0] miss_addr;
  logic                 miss_ready;
  logic [WAY_W-1:0]     victim_way;
  logic                 replace;
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [ADDR_SIZE-1:0] mem_req_addr;
  logic                 mem_rsp_valid;
  logic [31:0]          mem_rsp_data;
  logic                 fill_we;
  logic [SET_W-1:0]     fill_set;
  logic [WAY_W-1:0]     fill_way;
  logic [OFF_W-1:0]     fill_offset;
  logic [31:0]          fill_data;
  logic                 tag_we;
  logic [TAG_W-1:0]     tag_value;
  logic                 busy;
  logic                 refill_done;
`ifdef CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN
  logic                 crit_valid;
  logic [31:0]          crit_data;
`endif

  // Controller side
  modport master (
    input  miss_valid, miss_addr, victim_way, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output miss_ready, replace, mem_req_valid, mem_req_addr, fill_we, fill_set, fill_way,
           fill_offset, fill_data, tag_we, tag_value, busy, refill_done
`ifdef CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN
    , output crit_valid, crit_data
`endif
  );

  // Lookup / memory / array side
  modport slave (
    output miss_valid, miss_addr, victim_way, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  miss_ready, replace, mem_req_valid, mem_req_addr, fill_we, fill_set, fill_way,
           fill_offset, fill_data, tag_we, tag_value, busy, refill_done
`ifdef CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN
    , input crit_valid, crit_data
`endif
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: accepts one miss, fetches the whole line from memory,
// writes each returned word into the data array, then commits tag/valid and
// pulses the replacement policy.
// Optional feature macro: CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN (fetch starts
// at the missing word, counter wraps, crit_valid/crit_data flag the first word).
module cache_miss_ctrl #(
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned NUM_SETS    = 16,
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input logic             clk,
  input logic             rst,
  cache_miss_ctrl_if.master bus
);
  localparam int unsigned SET_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned TAG_W = ADDR_SIZE - SET_W - OFF_W - 2;

  typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} state_t;

  state_t           state_q;
  logic [TAG_W-1:0] tag_q;
  logic [SET_W-1:0] set_q;
  logic [OFF_W-1:0] off_q;
  logic [WAY_W-1:0] way_q;
  logic [OFF_W-1:0] cnt_q;
  logic [OFF_W-1:0] cnt_inc;
  logic [OFF_W-1:0] cnt_start;
  logic             miss_ready_q;
  logic             busy_q;
  logic             req_valid_q;
  logic             commit_q;
  logic             word_in;

  assign word_in = (state_q == FILL) && bus.mem_rsp_valid;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN
  logic first_q;
  logic unused_bits;
  assign unused_bits  = &{1'b0, bus.miss_addr[1:0]};
  assign cnt_start    = off_q;
  assign bus.mem_req_addr = {tag_q, set_q, off_q, 2'b00};
  assign bus.crit_valid   = word_in && first_q;
  assign bus.crit_data    = (word_in && first_q) ? bus.mem_rsp_data : '0;

  // Marks the first word of the burst (the critical word)
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b0;
    end else if (state_q == REQ && bus.mem_req_ready) begin
      first_q <= 1'b1;
    end else if (word_in) begin
      first_q <= 1'b0;
    end
  end
`else
  logic unused_bits;
  assign unused_bits  = &{1'b0, bus.miss_addr[1:0], off_q};
  assign cnt_start    = '0;
  assign bus.mem_req_addr = {tag_q, set_q, {(OFF_W + 2){1'b0}}};
`endif

  // Main refill FSM with registered handshake/commit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      set_q        <= '0;
      off_q        <= '0;
      way_q        <= '0;
      cnt_q        <= '0;
      miss_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.miss_valid) begin
            tag_q        <= bus.miss_addr[ADDR_SIZE-1 -: TAG_W];
            set_q        <= bus.miss_addr[OFF_W+2 +: SET_W];
            off_q        <= bus.miss_addr[2 +: OFF_W];
            way_q        <= bus.victim_way;
`ifdef CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN
            cnt_q        <= bus.miss_addr[2 +: OFF_W];
`else
            cnt_q        <= '0;
`endif
            miss_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            req_valid_q  <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_rsp_valid) begin
            cnt_q <= cnt_inc;
            // Burst ends when the wrapped counter comes back to its start
            if (cnt_inc == cnt_start) begin
              commit_q <= 1'b1;
              state_q  <= COMMIT;
            end
          end
        end
        COMMIT: begin
          miss_ready_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.miss_ready    = miss_ready_q;
  assign bus.busy          = busy_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.tag_we        = commit_q;
  assign bus.replace       = commit_q;
  assign bus.refill_done   = commit_q;
  assign bus.tag_value     = tag_q;
  assign bus.fill_we       = word_in;
  assign bus.fill_set      = set_q;
  assign bus.fill_way      = way_q;
  assign bus.fill_offset   = cnt_q;
  assign bus.fill_data     = word_in ? bus.mem_rsp_data : '0;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: inputs driven on the falling edge,
// outputs checked 1 ns later, one refill step per clock.
// Optional feature macro: CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN selects the critical-word-first scenario.
module tb_cache_miss_ctrl;
  logic clk = 1'b0;
  logic rst;
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned replace_cnt = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl_if #(.ADDR_SIZE(32), .NUM_SETS(16), .NUM_WAYS(4), .BLOCK_WORDS(4)) bus ();

  cache_miss_ctrl #(.ADDR_SIZE(32), .NUM_SETS(16), .NUM_WAYS(4), .BLOCK_WORDS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Count replace pulses seen at clock edges
  always @(posedge clk) if (bus.replace === 1'b1) replace_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [6:0] pat;
    int unsigned k;
    rst = 1'b1;
    bus.miss_valid = 1'b0;  bus.miss_addr = '0;     bus.victim_way = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_miss_ready", bus.miss_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_req_addr", bus.mem_req_addr, 0);
    chk("rst_fill_we", bus.fill_we, 0);
    chk("rst_commit", {bus.tag_we, bus.replace, bus.refill_done}, 0);
    chk("rst_fields", {bus.fill_set, bus.fill_way, bus.fill_offset, bus.tag_value}, 0);
    chk("rst_fill_data", bus.fill_data, 0);

`ifndef CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN
    // Zero-wait miss, victim_way changes 2->3 after acceptance
    @(negedge clk);
    bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_1234; bus.victim_way = 2'd2;
    bus.mem_req_ready = 1'b1;
    #1 chk("t1_accept_ready", bus.miss_ready, 1);
    @(negedge clk);                                   // T+1
    bus.miss_valid = 1'b0; bus.victim_way = 2'd3;
    #1;
    chk("t1_req_valid", bus.mem_req_valid, 1);
    chk("t1_req_addr", bus.mem_req_addr, 64'h1230);
    chk("t1_busy", bus.busy, 1);
    chk("t1_miss_ready", bus.miss_ready, 0);
    for (int i = 0; i < 4; i++) begin                 // T+2..T+5
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hD000_0000 + 32'(i);
      #1;
      chk("t1_fill_we", bus.fill_we, 1);
      chk("t1_fill_off", bus.fill_offset, 64'(i));
      chk("t1_fill_data", bus.fill_data, 64'hD000_0000 + 64'(i));
      chk("t1_fill_set_way", {bus.fill_set, bus.fill_way}, {4'd3, 2'd2});
      chk("t1_no_replace", bus.replace, 0);
    end
    @(negedge clk);                                   // T+6: COMMIT
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("t1_commit", {bus.tag_we, bus.replace, bus.refill_done}, 3'b111);
    chk("t1_tag", bus.tag_value, 64'h12);
    chk("t1_commit_way", bus.fill_way, 2);
    chk("t1_commit_ready", bus.miss_ready, 0);
    @(negedge clk);                                   // T+7
    #1;
    chk("t1_idle_ready", bus.miss_ready, 1);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_pulse_off", {bus.tag_we, bus.replace, bus.refill_done}, 0);
    chk("t1_replace_cnt", replace_cnt, 1);

    // Backpressure: 5 cycles of mem_req_ready low; stray responses in REQ ignored
    bus.mem_req_ready = 1'b0;
    bus.miss_valid = 1'b1; bus.miss_addr = 32'hABCD_0044; bus.victim_way = 2'd1;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_rsp_valid = (i == 2);
      #1;
      chk("t2_req_valid", bus.mem_req_valid, 1);
      chk("t2_req_addr", bus.mem_req_addr, 64'hABCD_0040);
      chk("t2_no_fill", bus.fill_we, 0);
      chk("t2_miss_ready", bus.miss_ready, 0);
      @(negedge clk);
    end
    bus.mem_rsp_valid = 1'b0; bus.mem_req_ready = 1'b1;
    #1 chk("t2_req_last", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, 32'hABCD_0040});
    @(negedge clk);
    bus.mem_req_ready = 1'b0;

    // Response gaps 1,0,0,1,1,0,1
    pat = 7'b1011001;   // bit 0 is the first cycle
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus.mem_rsp_valid = pat[i]; bus.mem_rsp_data = 32'hA0 + 32'(i);
      #1;
      chk("t3_fill_we", bus.fill_we, 64'(pat[i]));
      if (pat[i]) begin
        chk("t3_fill_off", bus.fill_offset, 64'(k));
        k++;
      end
      chk("t3_set_way", {bus.fill_set, bus.fill_way}, {4'd4, 2'd1});
      @(negedge clk);
    end
    // COMMIT, with a new miss already waiting
    bus.mem_rsp_valid = 1'b0;
    bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_1234; bus.victim_way = 2'd2;
    #1;
    chk("t3_commit", {bus.tag_we, bus.replace, bus.refill_done}, 3'b111);
    chk("t3_tag", bus.tag_value, 64'hABCD00);
    chk("t3_commit_no_accept", bus.miss_ready, 0);
    @(negedge clk);
    #1;
    chk("t3_idle_ready", bus.miss_ready, 1);
    chk("t3_idle_no_req", bus.mem_req_valid, 0);
    chk("t3_replace_cnt", replace_cnt, 2);

    // Reset mid-FILL after two words
    @(negedge clk);
    bus.miss_valid = 1'b0; bus.mem_req_ready = 1'b1;
    #1 chk("t4_req", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, 32'h0000_1230});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hB0 + 32'(i);
      #1 chk("t4_fill_off", {bus.fill_we, bus.fill_offset}, {1'b1, 2'(i)});
    end
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_ready", bus.miss_ready, 1);
    chk("t4_busy", bus.busy, 0);
    chk("t4_no_commit", {bus.tag_we, bus.replace, bus.refill_done}, 0);
    bus.mem_rsp_valid = 1'b1;
    #1 chk("t4_stray_no_fill", bus.fill_we, 0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("t4_still_idle", {bus.miss_ready, bus.busy}, 2'b10);
    chk("t4_replace_cnt", replace_cnt, 2);
`else
    // Critical word first: miss on word 2
    @(negedge clk);
    bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_1238; bus.victim_way = 2'd2;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    #1 chk("c_req_addr", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, 32'h0000_1238});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hC0 + 32'(i);
      #1;
      chk("c_fill_off", {bus.fill_we, bus.fill_offset}, {1'b1, 2'((i + 2) % 4)});
      chk("c_crit_valid", bus.crit_valid, 64'(i == 0));
      if (i == 0) chk("c_crit_data", bus.crit_data, 64'hC0);
    end
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    #1 chk("c_commit", {bus.tag_we, bus.replace, bus.crit_valid}, 3'b110);
    @(negedge clk);
    #1 chk("c_idle", bus.miss_ready, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 32: byte address width.
REQ-002 The block SHALL have parameter NUM_SETS, default 16: cache sets, a power of two.
REQ-003 The block SHALL have parameter NUM_WAYS, default 4: associativity, a power of two.
REQ-004 The block SHALL have parameter BLOCK_WORDS, default 4: 32-bit words per line, a power of two.
REQ-005 The block SHALL derive these widths: SET_W=clog2(NUM_SETS), WAY_W=clog2(NUM_WAYS), OFF_W=clog2(BLOCK_WORDS), TAG_W=ADDR_SIZE-SET_W-OFF_W-2.
REQ-006 The block SHALL have these ports:
  clk  in  1  clock.
  rst  in  1  reset: synchronous, active-high.
  miss_valid  in  1  lookup stage reports a miss.
  miss_addr  in  ADDR_SIZE  missing byte address.
  miss_ready  out  1  miss accepted.
  victim_way  in  WAY_W  preferred way from the replacement policy.
  replace  out  1  one-cycle pulse that advances the replacement policy.
  mem_req_valid  out  1  line-fetch request.
  mem_req_ready  in  1  memory accepts the request.
  mem_req_addr  out  ADDR_SIZE  fetch start address.
  mem_rsp_valid  in  1  response word valid.
  mem_rsp_data  in  32  response word.
  fill_we  out  1  data-array write enable.
  fill_set  out  SET_W  data-array set.
  fill_way  out  WAY_W  data-array way.
  fill_offset  out  OFF_W  data-array word offset.
  fill_data  out  32  data-array write data.
  tag_we  out  1  tag/valid write enable.
  tag_value  out  TAG_W  tag written to (fill_set, fill_way).
  busy  out  1  refill in progress.
  refill_done  out  1  one-cycle completion pulse.

Function
REQ-007 The FSM SHALL have four states, IDLE, REQ, FILL and COMMIT, with these transitions: IDLE->REQ on miss_valid; REQ->FILL on mem_req_ready; FILL->COMMIT on the BLOCK_WORDS-th mem_rsp_valid; COMMIT->IDLE unconditionally.
REQ-008 miss_ready SHALL equal (state==IDLE); a miss is accepted when miss_valid && miss_ready.
REQ-009 On acceptance, the block SHALL latch the tag, set and word offset from miss_addr, and SHALL latch victim_way, which then drives fill_way until return to IDLE.
REQ-010 mem_req_valid SHALL be high exactly in REQ and held until mem_req_ready, with mem_req_addr stable throughout.
REQ-011 In FILL, fill_we SHALL equal mem_rsp_valid combinationally, with fill_data=mem_rsp_data and fill_offset=word counter; the counter SHALL increment modulo BLOCK_WORDS per valid word.
REQ-012 mem_rsp_valid outside FILL SHALL be ignored, with no writes and no state change.
REQ-013 In COMMIT, tag_we, replace and refill_done SHALL all be high for exactly that one cycle.
REQ-014 replace SHALL never assert outside COMMIT, giving exactly one pulse per refill.
REQ-015 busy SHALL equal (state!=IDLE).
REQ-016 Zero-wait latency SHALL be: accept at T, mem_req_valid at T+1, words T+2..T+1+BLOCK_WORDS, COMMIT at T+2+BLOCK_WORDS, miss_ready at T+3+BLOCK_WORDS.
REQ-017 A miss_valid asserted in COMMIT SHALL be accepted no earlier than the following IDLE cycle.

Reset
REQ-018 While rst is high at a clock edge, the block SHALL go to IDLE and clear the word counter and all latched fields.
REQ-019 After reset, all outputs SHALL be 0 except miss_ready=1.
REQ-020 Reset in REQ or FILL SHALL abandon the refill with no tag_we and no replace; the data-array contents written so far are don't-care.

Configuration
REQ-021 The feature macro SHALL be CACHE_MISS_CTRL_CRITICAL_WORD_FIRST_EN.
REQ-022 When the macro is undefined: mem_req_addr SHALL be block-aligned (low OFF_W+2 bits zero), and the counter SHALL start at 0.
REQ-023 When the macro is defined: mem_req_addr SHALL be word-aligned to the miss word, the counter SHALL start at the latched offset and wrap modulo BLOCK_WORDS, and extra outputs crit_valid (1) and crit_data (32) SHALL pulse with the first FILL word.

Verification
REQ-024 The bench SHALL cover a zero-wait miss: miss_addr=0x0000_1234, victim_way=2, mem_req_ready=1, rsp D0..D3 back-to-back -> mem_req_addr=0x0000_1230 (macro off), fill set=3, way=2, offsets 0..3, tag=0x0000_12, COMMIT at T+6, one replace pulse.
REQ-025 The bench SHALL cover backpressure: mem_req_ready low 5 cycles -> mem_req_valid/addr stable 5 cycles, no fill_we, miss_ready=0.
REQ-026 The bench SHALL cover response gaps: rsp_valid pattern 1,0,0,1,1,0,1 -> exactly 4 fill_we, offsets 0..3 in order, then COMMIT.
REQ-027 The bench SHALL cover reset mid-FILL after 2 words -> IDLE next cycle, no tag_we/replace, miss_ready=1; a stray rsp_valid afterwards gives no fill_we.
REQ-028 The bench SHALL cover macro on with miss_addr=0x0000_1238 -> mem_req_addr=0x0000_1238, offsets 2,3,0,1, crit_valid with the first word only.
REQ-029 The bench SHALL cover victim_way changing after acceptance (2->3) -> fill_way stays 2 for the whole refill.
